// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared definitions for the 3x3 systolic array feed controller.
//   SYS_DW   : default operand element width
//   SYS_N    : array edge size (rows = columns = 3)
//   state_e  : sequencer state encoding
//   flat_idx : element index of [row][col] in a row-major flat bus
package systolic_pkg;

  localparam int unsigned SYS_DW = 8;
  localparam int unsigned SYS_N  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int unsigned flat_idx(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned ncols);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_skew_lane.sv
// One skewed edge lane of the systolic array feed.
//   i_t    : current feed beat
//   i_vec  : K operand elements, element k at bits k*DW +: DW
//   o_elem : element (i_t - LANE) when 0 <= i_t - LANE < K, else 0
module systolic_skew_lane #(
  parameter int unsigned DW   = 8,
  parameter int unsigned K    = 3,
  parameter int unsigned LANE = 0,
  parameter int unsigned TW   = $clog2(K + 4)
) (
  input  logic [TW-1:0]   i_t,
  input  logic [K*DW-1:0] i_vec,
  output logic [DW-1:0]   o_elem
);

  always_comb begin
    o_elem = '0;
    for (int unsigned k = 0; k < K; k++) begin
      if (i_t == TW'(LANE + k)) begin
        o_elem = i_vec[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for the 3x3 output-stationary systolic PE array.
// Captures A (3xK) and B (Kx3) on start, pulses acc_clr, feeds the six array
// edges with diagonal skew for K+4 beats, waits DRAIN_CYC cycles, pulses done.
//   clk, rst          : clock, asynchronous active-low reset
//   start             : run request, sampled only in IDLE
//   a_flat, b_flat    : operand matrices, row-major flat buses
//   busy, done        : run in progress / one-cycle completion pulse
//   acc_clr           : one-cycle accumulator clear
//   feed_valid        : high on feed beats
//   left1..3, up1..3  : row and column edge operands
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned DW        = SYS_DW,
  parameter int unsigned K         = 3,
  parameter int unsigned DRAIN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3*K*DW-1:0]    a_flat,
  input  logic [K*3*DW-1:0]    b_flat,
  output logic                 busy,
  output logic                 done,
  output logic                 acc_clr,
  output logic                 feed_valid,
  output logic [DW-1:0]        left1,
  output logic [DW-1:0]        left2,
  output logic [DW-1:0]        left3,
  output logic [DW-1:0]        up1,
  output logic [DW-1:0]        up2,
  output logic [DW-1:0]        up3
);

  localparam int unsigned TW  = $clog2(K + 4);
  localparam int unsigned DCW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);

  state_e               r_state;
  state_e               w_next;
  logic [3*K*DW-1:0]    r_a;
  logic [K*3*DW-1:0]    r_b;
  logic [TW-1:0]        r_t;
  logic [DCW-1:0]       r_drain;
  logic                 w_t_last;
  logic                 w_drain_last;
  logic                 w_feed;
  logic [K*DW-1:0]      w_row [SYS_N];
  logic [K*DW-1:0]      w_col [SYS_N];
  logic [DW-1:0]        w_left [SYS_N];
  logic [DW-1:0]        w_up   [SYS_N];

  assign w_t_last     = (r_t == TW'(K + 3));
  assign w_drain_last = (r_drain == DCW'(DRAIN_CYC - 1));
  assign w_feed       = (r_state == ST_FEED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_CLEAR;
      ST_CLEAR: w_next = ST_FEED;
      ST_FEED:  if (w_t_last) w_next = (DRAIN_CYC == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (w_drain_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_t     <= '0;
      r_drain <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_a <= a_flat;
        r_b <= b_flat;
      end
      if (w_feed && !w_t_last) begin
        r_t <= r_t + TW'(1);
      end else begin
        r_t <= '0;
      end
      if (r_state == ST_DRAIN && !w_drain_last) begin
        r_drain <= r_drain + DCW'(1);
      end else begin
        r_drain <= '0;
      end
    end
  end

  // Regroup captured operands: row i holds A[i][0..K-1], column j holds
  // B[0..K-1][j], each as a contiguous K-element vector for the skew lanes.
  always_comb begin
    for (int unsigned i = 0; i < SYS_N; i++) begin
      w_row[i] = '0;
      w_col[i] = '0;
    end
    for (int unsigned i = 0; i < SYS_N; i++) begin
      for (int unsigned k = 0; k < K; k++) begin
        w_row[i][k*DW +: DW] = r_a[flat_idx(i, k, K)*DW +: DW];
        w_col[i][k*DW +: DW] = r_b[flat_idx(k, i, SYS_N)*DW +: DW];
      end
    end
  end

  for (genvar g = 0; g < SYS_N; g++) begin : g_lane
    systolic_skew_lane #(
      .DW   (DW),
      .K    (K),
      .LANE (g),
      .TW   (TW)
    ) u_row (
      .i_t    (r_t),
      .i_vec  (w_row[g]),
      .o_elem (w_left[g])
    );
    systolic_skew_lane #(
      .DW   (DW),
      .K    (K),
      .LANE (g),
      .TW   (TW)
    ) u_col (
      .i_t    (r_t),
      .i_vec  (w_col[g]),
      .o_elem (w_up[g])
    );
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign acc_clr    = (r_state == ST_CLEAR);
  assign feed_valid = w_feed;

  // Lanes see a zero beat counter outside FEED, so gate to keep the edges
  // silent in CLEAR/DRAIN/DONE/IDLE.
  assign left1 = w_feed ? w_left[0] : '0;
  assign left2 = w_feed ? w_left[1] : '0;
  assign left3 = w_feed ? w_left[2] : '0;
  assign up1   = w_feed ? w_up[0]   : '0;
  assign up2   = w_feed ? w_up[1]   : '0;
  assign up3   = w_feed ? w_up[2]   : '0;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench for systolic_feed_ctrl (DW=8, K=3, DRAIN_CYC=1).
module tb_systolic_feed_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [71:0] a_flat;
  logic [71:0] b_flat;
  logic        busy, done, acc_clr, feed_valid;
  logic [7:0]  left1, left2, left3, up1, up2, up3;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] l1, l2, l3, u1, u2, u3;
    logic       clr, fv, dn, bsy;
  } exp_t;

  exp_t tbl [12];
  logic [7:0] hist_l [3][7];
  logic [7:0] hist_u [3][7];

  systolic_feed_ctrl #(.DW(8), .K(3), .DRAIN_CYC(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .busy       (busy),
    .done       (done),
    .acc_clr    (acc_clr),
    .feed_valid (feed_valid),
    .left1      (left1),
    .left2      (left2),
    .left3      (left3),
    .up1        (up1),
    .up2        (up2),
    .up3        (up3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int l1, input int l2, input int l3,
                              input int u1, input int u2, input int u3,
                              input int clr, input int fv, input int dn, input int bsy);
    exp_t e;
    e.l1 = 8'(l1); e.l2 = 8'(l2); e.l3 = 8'(l3);
    e.u1 = 8'(u1); e.u2 = 8'(u2); e.u3 = 8'(u3);
    e.clr = 1'(clr); e.fv = 1'(fv); e.dn = 1'(dn); e.bsy = 1'(bsy);
    return e;
  endfunction

  function automatic logic [51:0] pk(input exp_t e);
    return {e.l1, e.l2, e.l3, e.u1, e.u2, e.u3, e.clr, e.fv, e.dn, e.bsy};
  endfunction

  function automatic logic [51:0] obs();
    return {left1, left2, left3, up1, up2, up3, acc_clr, feed_valid, done, busy};
  endfunction

  // A = [1 2 3; 4 5 6; 7 8 9], B = identity
  task automatic load_basic();
    a_flat = '0;
    b_flat = '0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        a_flat[(i*3+k)*8 +: 8] = 8'(3*i + k + 1);
      end
      b_flat[(i*3+i)*8 +: 8] = 8'd1;
    end
  endtask

  // Start a run and compare cycles 1..11 against the table. With disturb,
  // start is pulsed in cycles 3 and 10 with scrambled buses.
  task automatic apply_table(input string nm, input bit disturb);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("%s_c%0d", nm, c), 64'(obs()), 64'(pk(tbl[c])));
      if (feed_valid && c >= 2 && c <= 8) begin
        hist_l[0][c-2] = left1; hist_l[1][c-2] = left2; hist_l[2][c-2] = left3;
        hist_u[0][c-2] = up1;   hist_u[1][c-2] = up2;   hist_u[2][c-2] = up3;
      end
      if (disturb && (c == 3 || c == 10)) begin
        start  = 1'b1;
        a_flat = 72'({$urandom, $urandom, $urandom});
        b_flat = 72'({$urandom, $urandom, $urandom});
      end else begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    int c;
    int dcnt;
    logic [7:0] lv, uv;
    int acc;

    tbl[0]  = mk(0,0,0, 0,0,0, 0,0,0,0);
    tbl[1]  = mk(0,0,0, 0,0,0, 1,0,0,1);
    tbl[2]  = mk(1,0,0, 1,0,0, 0,1,0,1);
    tbl[3]  = mk(2,4,0, 0,0,0, 0,1,0,1);
    tbl[4]  = mk(3,5,7, 0,1,0, 0,1,0,1);
    tbl[5]  = mk(0,6,8, 0,0,0, 0,1,0,1);
    tbl[6]  = mk(0,0,9, 0,0,1, 0,1,0,1);
    tbl[7]  = mk(0,0,0, 0,0,0, 0,1,0,1);
    tbl[8]  = mk(0,0,0, 0,0,0, 0,1,0,1);
    tbl[9]  = mk(0,0,0, 0,0,0, 0,0,0,1);
    tbl[10] = mk(0,0,0, 0,0,0, 0,0,1,1);
    tbl[11] = mk(0,0,0, 0,0,0, 0,0,0,0);

    // Reset held with start high and random buses
    rst    = 1'b0;
    start  = 1'b1;
    a_flat = 72'({$urandom, $urandom, $urandom});
    b_flat = 72'({$urandom, $urandom, $urandom});
    #1;
    chk("rst_async", 64'(obs()), 64'd0);
    tick(); tick(); tick();
    chk("rst_hold", 64'(obs()), 64'd0);
    start = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_rel_busy%0d", i), 64'(busy), 64'd0);
    end

    // Basic run
    load_basic();
    apply_table("basic", 1'b0);

    // PE array model: PE(i,j) sees left_i delayed by j and up_j delayed by i
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = 0;
        for (int t = 0; t < 11; t++) begin
          lv = (t - j >= 0 && t - j < 7) ? hist_l[i][t-j] : 8'd0;
          uv = (t - i >= 0 && t - i < 7) ? hist_u[j][t-i] : 8'd0;
          acc += int'(lv) * int'(uv);
        end
        chk($sformatf("pe_C%0d%0d", i, j), 64'(acc), 64'(3*i + j + 1));
      end
    end

    // Skew edges with all-ones operands
    a_flat = '1;
    b_flat = '1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int cc = 1; cc <= 11; cc++) begin
      if (cc >= 2 && cc <= 8) begin
        chk($sformatf("skew_fv_t%0d", cc-2), 64'(feed_valid), 64'd1);
        chk($sformatf("skew_left3_t%0d", cc-2), 64'(left3),
            (cc-2 >= 2 && cc-2 <= 4) ? 64'hFF : 64'd0);
        chk($sformatf("skew_up1_t%0d", cc-2), 64'(up1),
            (cc-2 <= 2) ? 64'hFF : 64'd0);
      end
      tick();
    end

    // start pulses while busy must not disturb the run
    load_basic();
    apply_table("busystart", 1'b1);

    // Reset mid-run at FEED t=3
    load_basic();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("midrst_pre_t3_left2", 64'(left2), 64'd6);
    rst = 1'b0;
    #1;
    chk("midrst_outs", 64'(obs()), 64'd0);
    tick(); tick();
    rst  = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) dcnt++;
    end
    chk("midrst_no_done", 64'(dcnt), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rerun_acc_clr", 64'(acc_clr), 64'd1);
    c = 1;
    while (!done && c < 40) begin
      tick();
      c++;
      if (c == 2) chk("rerun_t0_left1", 64'(left1), 64'd1);
    end
    chk("rerun_done_cycle", 64'(c), 64'd10);
    tick();
    chk("rerun_done_width", 64'(done), 64'd0);

    // Back-to-back runs with start held high
    start = 1'b1;
    tick();
    for (int cc = 1; cc <= 25; cc++) begin
      chk($sformatf("b2b_done_c%0d", cc), 64'(done),
          (cc == 10 || cc == 21) ? 64'd1 : 64'd0);
      chk($sformatf("b2b_busy_c%0d", cc), 64'(busy),
          (cc == 11 || cc == 22) ? 64'd0 : 64'd1);
      tick();
    end
    start = 1'b0;
    c = 0;
    while (busy && c < 30) begin
      tick();
      c++;
    end
    chk("b2b_settle_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
